i2s_rx_param: RTL

I2S_RX_PARAM -- requirements
Module: i2s_rx_param

---
 rtl/i2s_rx_param.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/i2s_rx_param.sv
// i2s_rx_param: I2S / left-justified stereo receiver.
// Oversamples sck/ws/sd on the system clock, assembles left-aligned
// left/right words and presents each completed pair on a valid/ready
// output with a sticky overrun flag for pairs dropped under backpressure.
module i2s_rx_param #(
    parameter int DATA_WIDTH  = 32,
    parameter int LJ_MODE     = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sck,
    input  logic                  ws,
    input  logic                  sd,
    input  logic                  en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_left,
    output logic [DATA_WIDTH-1:0] out_right,
    output logic [5:0]            slot_len,
    output logic                  overrun,
    input  logic                  clr_overrun
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LEFT = 2'd1,
        RX_LEFT   = 2'd2,
        RX_RIGHT  = 2'd3
    } state_t;

    localparam bit                  LJ      = (LJ_MODE != 0);
    localparam logic [DATA_WIDTH-1:0] MSB_ONE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ZERO_W  = {DATA_WIDTH{1'b0}};

    logic [SYNC_STAGES-1:0] sck_sync_r, ws_sync_r, sd_sync_r;
    logic                   sck_prev_r, ws_prev_r;
    logic                   sck_s, ws_s, sd_s, strobe_s, ws_chg_s;

    state_t                 state_r, state_nxt;
    logic [DATA_WIDTH-1:0]  sh_r, sh_nxt, left_r, left_nxt;
    logic [5:0]             cnt_r, cnt_nxt, slot_len_r, slot_len_nxt;

    logic [DATA_WIDTH-1:0]  sh_ins_s, close_word_s, open_sh_s;
    logic [5:0]             cnt_inc_s, close_len_s, open_cnt_s;
    logic                   push_s, ovr_set_s;

    logic                   out_valid_r, overrun_r;
    logic [DATA_WIDTH-1:0]  out_left_r, out_right_r;

    // Synchronise the asynchronous I2S inputs and remember the previous sck level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_r <= {SYNC_STAGES{1'b0}};
            ws_sync_r  <= {SYNC_STAGES{1'b0}};
            sd_sync_r  <= {SYNC_STAGES{1'b0}};
            sck_prev_r <= 1'b0;
        end else begin
            sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], sck};
            ws_sync_r  <= {ws_sync_r[SYNC_STAGES-2:0], ws};
            sd_sync_r  <= {sd_sync_r[SYNC_STAGES-2:0], sd};
            sck_prev_r <= sck_s;
        end
    end

    assign sck_s    = sck_sync_r[SYNC_STAGES-1];
    assign ws_s     = ws_sync_r[SYNC_STAGES-1];
    assign sd_s     = sd_sync_r[SYNC_STAGES-1];
    assign strobe_s = sck_s & ~sck_prev_r;
    assign ws_chg_s = strobe_s & (ws_s ^ ws_prev_r);

    // Track ws as seen on the previous sck rise for change detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws_prev_r <= 1'b0;
        end else if (strobe_s) begin
            ws_prev_r <= ws_s;
        end
    end

    // Slot arithmetic: the bit goes in at the MSB-first position given by the
    // count, so short slots leave zero LSBs and long slots fall off the end.
    // In Philips mode the change-strobe bit closes the old slot; in
    // left-justified mode it opens the new one as its MSB.
    always_comb begin
        sh_ins_s     = sd_s ? (sh_r | (MSB_ONE >> cnt_r)) : sh_r;
        cnt_inc_s    = (cnt_r == 6'd63) ? 6'd63 : (cnt_r + 6'd1);
        close_word_s = LJ ? sh_r  : sh_ins_s;
        close_len_s  = LJ ? cnt_r : cnt_inc_s;
        open_sh_s    = (LJ && sd_s) ? MSB_ONE : ZERO_W;
        open_cnt_s   = LJ ? 6'd1 : 6'd0;
    end

    // Receiver FSM: next state, shift/count, left latch and pair push.
    always_comb begin
        state_nxt    = state_r;
        sh_nxt       = sh_r;
        cnt_nxt      = cnt_r;
        left_nxt     = left_r;
        slot_len_nxt = slot_len_r;
        push_s       = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            sh_nxt    = ZERO_W;
            cnt_nxt   = 6'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt = WAIT_LEFT;
                end
                WAIT_LEFT: begin
                    if (strobe_s && ws_prev_r && !ws_s) begin
                        state_nxt = RX_LEFT;
                        sh_nxt    = open_sh_s;
                        cnt_nxt   = open_cnt_s;
                    end else begin
                        state_nxt = WAIT_LEFT;
                    end
                end
                RX_LEFT, RX_RIGHT: begin
                    if (ws_chg_s) begin
                        slot_len_nxt = close_len_s;
                        sh_nxt       = open_sh_s;
                        cnt_nxt      = open_cnt_s;
                        if (state_r == RX_LEFT) begin
                            left_nxt  = close_word_s;
                            state_nxt = RX_RIGHT;
                        end else begin
                            push_s    = 1'b1;
                            state_nxt = RX_LEFT;
                        end
                    end else if (strobe_s) begin
                        sh_nxt  = sh_ins_s;
                        cnt_nxt = cnt_inc_s;
                    end else begin
                        state_nxt = state_r;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            sh_r       <= ZERO_W;
            cnt_r      <= 6'd0;
            left_r     <= ZERO_W;
            slot_len_r <= 6'd0;
        end else begin
            state_r    <= state_nxt;
            sh_r       <= sh_nxt;
            cnt_r      <= cnt_nxt;
            left_r     <= left_nxt;
            slot_len_r <= slot_len_nxt;
        end
    end

    assign ovr_set_s = push_s & out_valid_r & ~out_ready;

    // Output holding stage: load on push when free or draining, else drop and flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_left_r  <= ZERO_W;
            out_right_r <= ZERO_W;
            overrun_r   <= 1'b0;
        end else begin
            if (push_s && (!out_valid_r || out_ready)) begin
                out_valid_r <= 1'b1;
                out_left_r  <= left_r;
                out_right_r <= close_word_s;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (clr_overrun) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_left  = out_left_r;
    assign out_right = out_right_r;
    assign slot_len  = slot_len_r;
    assign overrun   = overrun_r;

endmodule
